// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default address/instruction widths and the NOP word shown on instr while
// no live instruction is present.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int DEFAULT_ADDR_W  = 16;
    localparam int DEFAULT_INSTR_W = 16;

    // Word driven on instr whenever instr_valid is low (all zeros).
    localparam logic [DEFAULT_INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding register for the instruction being presented while the
// consumer is stalled. When the fetch unit keeps reading memory during a
// stall, mem_rdata no longer holds the presented word, so the word that was
// on mem_rdata when the stall began is captured here and shown until the
// stall is released.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset, empties the buffer
//   hold         1 = stall in progress: capture once, then keep the entry
//                0 = empty the buffer
//   capture_data word to capture on the first hold cycle
//   full         buffer holds a captured word
//   held_data    captured word
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_INSTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [WIDTH-1:0] capture_data,
    output logic             full,
    output logic [WIDTH-1:0] held_data
);

    // Capture only on the first hold cycle so the entry stays put while the
    // memory keeps returning newer data underneath it.
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 1'b0;
            held_data <= '0;
        end else if (!hold) begin
            full <= 1'b0;
        end else if (!full) begin
            full      <= 1'b1;
            held_data <= capture_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: owns the PC register, issues reads to a
// synchronous instruction memory (1-cycle latency) and presents the fetched
// word with its address to the decode stage. Handles downstream stall,
// taken-jump squash and reset.
//
// Build option: define FETCH_SKID_EN to keep mem_rd_en a function of the
// registered FSM state only (no path from stall); a one-entry skid buffer
// (fetch_skid_buf) then holds the presented word during a stall. Without the
// macro, mem_rd_en is gated by stall and instr comes straight from the held
// mem_rdata. Both builds give the same instruction stream at the interface.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   next_pc      next PC from the PC-select mux
//   jump_en      taken jump; loads next_pc and squashes the in-flight fetch
//   stall        downstream not ready (accept = instr_valid && !stall)
//   pc           current PC register
//   mem_addr     instruction memory address (always equal to pc)
//   mem_rd_en    instruction memory read strobe
//   mem_rdata    memory data, valid one cycle after mem_rd_en
//   instr        fetched instruction (NOP when not valid)
//   instr_pc     address of the instruction on instr
//   instr_valid  instr/instr_pc hold a live instruction
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               ADDR_W   = DEFAULT_ADDR_W,
    parameter int               INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  next_pc,
    input  logic               jump_en,
    input  logic               stall,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd_en,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    fetch_state_t       state;
    fetch_state_t       next_state;
    logic               issue;
    logic               take_jump;
    logic [INSTR_W-1:0] fetched_word;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. "issue" marks a read whose data will
    // become the next presented instruction; pc advances only on such reads,
    // so a read made during a stall is simply repeated later and never lost
    // or delivered twice. A jump beats a stall.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        take_jump  = 1'b0;
        mem_rd_en  = 1'b0;
        case (state)
            BOOT: begin
                next_state = RUN;
            end
            RUN, HOLD: begin
`ifdef FETCH_SKID_EN
                mem_rd_en = 1'b1;
`else
                mem_rd_en = !stall;
`endif
                if (jump_en) begin
                    take_jump  = 1'b1;
                    next_state = SQUASH;
                end else if (stall) begin
                    next_state = HOLD;
                end else begin
                    issue      = 1'b1;
                    next_state = RUN;
                end
            end
            SQUASH: begin
                // Nothing is presented here, so the target read is issued
                // even if the consumer is stalled.
                mem_rd_en = 1'b1;
                if (jump_en) begin
                    take_jump  = 1'b1;
                    next_state = SQUASH;
                end else begin
                    issue      = 1'b1;
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // PC and presented-instruction bookkeeping. The word itself is not
    // registered here: it arrives on mem_rdata in the cycle instr_valid rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
        end else if (take_jump) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
        end else if (issue) begin
            pc          <= next_pc;
            instr_valid <= 1'b1;
            instr_pc    <= pc;
        end
    end

`ifdef FETCH_SKID_EN
    logic               skid_hold;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_data;

    // Memory keeps reading during a stall, so freeze the presented word.
    assign skid_hold = ((state == RUN) || (state == HOLD)) && stall && !jump_en;

    fetch_skid_buf #(
        .WIDTH(INSTR_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .hold        (skid_hold),
        .capture_data(mem_rdata),
        .full        (skid_full),
        .held_data   (skid_data)
    );

    assign fetched_word = skid_full ? skid_data : mem_rdata;
`else
    assign fetched_word = mem_rdata;
`endif

    assign mem_addr = pc;
    assign instr    = instr_valid ? fetched_word : INSTR_W'(NOP_INSTR);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed, table-driven bench for instr_fetch. Each vector gives the inputs
// for one cycle and the outputs expected during that cycle. Memory word at
// address a is a ^ 16'h5A5A.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jump_en;
    logic [15:0] jump_target;
    logic [15:0] next_pc;
    logic [15:0] pc;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;

    int assertCount  = 0;
    int failureCount = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        jump;
        logic [15:0] target;
        bit          chk;
        logic        valid;
        bit          careIpc;
        logic [15:0] ipc;
        logic [15:0] pc;
        logic        rdPlain;
        logic        rdSkid;
    } vec_t;

    vec_t vecs[31];

    instr_fetch #(
        .ADDR_W  (16),
        .INSTR_W (16),
        .RESET_PC(16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .jump_en    (jump_en),
        .stall      (stall),
        .pc         (pc),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // PC-select mux: sequential unless a jump is taken.
    assign next_pc = jump_en ? jump_target : pc + 16'd1;

    function automatic logic [15:0] wordAt(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Synchronous instruction memory, data held while not reading.
    initial mem_rdata = 16'h0000;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= wordAt(mem_addr);
    end

    function automatic vec_t mk(input logic r, input logic s, input logic j,
                                input logic [15:0] t, input bit c,
                                input logic v, input bit ci, input logic [15:0] ipc,
                                input logic [15:0] p, input logic rdp, input logic rds);
        vec_t x;
        x.rst = r; x.stall = s; x.jump = j; x.target = t; x.chk = c;
        x.valid = v; x.careIpc = ci; x.ipc = ipc; x.pc = p;
        x.rdPlain = rdp; x.rdSkid = rds;
        return x;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        stall       = v.stall;
        jump_en     = v.jump;
        jump_target = v.target;
        #1;
    endtask

    task automatic checkValue(input string name, input string tag, input int step,
                              input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failureCount++;
            $display("[TB] FAIL %s %s step %0d: got %h expected %h", tag, name, step, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int step, input vec_t v);
        logic [15:0] expInstr;
        expInstr = v.valid ? wordAt(v.ipc) : 16'h0000;
        checkValue("pc", tag, step, 32'(pc), 32'(v.pc));
        checkValue("mem_addr", tag, step, 32'(mem_addr), 32'(v.pc));
        checkValue("mem_rd_en", tag, step, 32'(mem_rd_en), 32'(SKID ? v.rdSkid : v.rdPlain));
        checkValue("instr_valid", tag, step, 32'(instr_valid), 32'(v.valid));
        checkValue("instr", tag, step, 32'(instr), 32'(expInstr));
        if (v.careIpc) checkValue("instr_pc", tag, step, 32'(instr_pc), 32'(v.ipc));
    endtask

    initial begin
        vec_t h;
        rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_target = 16'h0000;

        // rst stall jump target | chk valid careIpc ipc pc | rdPlain rdSkid
        vecs[0]  = mk(1,0,0,16'h0000, 0, 0,0,16'h0000,16'h0000, 0,0);
        vecs[1]  = mk(1,0,0,16'h0000, 1, 0,1,16'h0000,16'h0000, 0,0); // reset state
        vecs[2]  = mk(0,0,0,16'h0000, 1, 0,1,16'h0000,16'h0000, 0,0); // BOOT
        vecs[3]  = mk(0,0,0,16'h0000, 1, 0,1,16'h0000,16'h0000, 1,1); // first read @0
        vecs[4]  = mk(0,0,0,16'h0000, 1, 1,1,16'h0000,16'h0001, 1,1); // first valid
        vecs[5]  = mk(0,0,0,16'h0000, 1, 1,1,16'h0001,16'h0002, 1,1);
        vecs[6]  = mk(0,0,0,16'h0000, 1, 1,1,16'h0002,16'h0003, 1,1);
        vecs[7]  = mk(0,0,0,16'h0000, 1, 1,1,16'h0003,16'h0004, 1,1);
        vecs[8]  = mk(0,0,0,16'h0000, 1, 1,1,16'h0004,16'h0005, 1,1);
        vecs[9]  = mk(0,1,0,16'h0000, 1, 1,1,16'h0005,16'h0006, 0,1); // stall x3
        vecs[10] = mk(0,1,0,16'h0000, 1, 1,1,16'h0005,16'h0006, 0,1);
        vecs[11] = mk(0,1,0,16'h0000, 1, 1,1,16'h0005,16'h0006, 0,1);
        vecs[12] = mk(0,0,0,16'h0000, 1, 1,1,16'h0005,16'h0006, 1,1); // release
        vecs[13] = mk(0,0,0,16'h0000, 1, 1,1,16'h0006,16'h0007, 1,1);
        vecs[14] = mk(0,0,0,16'h0000, 1, 1,1,16'h0007,16'h0008, 1,1);
        vecs[15] = mk(0,0,1,16'h0ABC, 1, 1,1,16'h0008,16'h0009, 1,1); // jump at pc=9
        vecs[16] = mk(0,0,0,16'h0000, 1, 0,0,16'h0000,16'h0ABC, 1,1); // squash
        vecs[17] = mk(0,0,0,16'h0000, 1, 1,1,16'h0ABC,16'h0ABD, 1,1);
        vecs[18] = mk(0,1,1,16'h0010, 1, 1,1,16'h0ABD,16'h0ABE, 0,1); // jump+stall
        vecs[19] = mk(0,0,0,16'h0000, 1, 0,0,16'h0000,16'h0010, 1,1);
        vecs[20] = mk(0,0,0,16'h0000, 1, 1,1,16'h0010,16'h0011, 1,1);
        vecs[21] = mk(0,0,1,16'hFFFF, 1, 1,1,16'h0011,16'h0012, 1,1); // jump to FFFF
        vecs[22] = mk(0,0,0,16'h0000, 1, 0,0,16'h0000,16'hFFFF, 1,1);
        vecs[23] = mk(0,0,0,16'h0000, 1, 1,1,16'hFFFF,16'h0000, 1,1); // wrap
        vecs[24] = mk(0,0,0,16'h0000, 1, 1,1,16'h0000,16'h0001, 1,1);
        vecs[25] = mk(0,1,0,16'h0000, 1, 1,1,16'h0001,16'h0002, 0,1); // into HOLD
        vecs[26] = mk(0,1,0,16'h0000, 1, 1,1,16'h0001,16'h0002, 0,1);
        vecs[27] = mk(1,1,1,16'h1234, 1, 1,1,16'h0001,16'h0002, 0,1); // rst in HOLD
        vecs[28] = mk(0,0,0,16'h0000, 1, 0,1,16'h0000,16'h0000, 0,0);
        vecs[29] = mk(0,0,0,16'h0000, 1, 0,1,16'h0000,16'h0000, 1,1);
        vecs[30] = mk(0,0,0,16'h0000, 1, 1,1,16'h0000,16'h0001, 1,1);

        $display("[TB] running %s build", SKID ? "skid" : "plain");
        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].chk) checkOutput("table", i, vecs[i]);
        end

        // Jump, then stall arriving in the SQUASH cycle and held in RUN/HOLD.
        h = mk(0,0,1,16'h0200, 1, 1,1,16'h0001,16'h0002, 1,1);
        applyStimulus(h); checkOutput("sqstall", 0, h);
        h = mk(0,1,0,16'h0000, 1, 0,0,16'h0000,16'h0200, 1,1);
        applyStimulus(h); checkOutput("sqstall", 1, h);
        h = mk(0,1,0,16'h0000, 1, 1,1,16'h0200,16'h0201, 0,1);
        applyStimulus(h); checkOutput("sqstall", 2, h);
        applyStimulus(h); checkOutput("sqstall", 3, h);
        h = mk(0,0,0,16'h0000, 1, 1,1,16'h0200,16'h0201, 1,1);
        applyStimulus(h); checkOutput("sqstall", 4, h);
        h = mk(0,0,0,16'h0000, 1, 1,1,16'h0201,16'h0202, 1,1);
        applyStimulus(h); checkOutput("sqstall", 5, h);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
        $finish;
    end

endmodule
